wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order writeback stage and a long-latency
//  result source (mul/div, CSR, late loads). Sits after the writeback select mux and drives the regfile
//  write port. Registered one-cycle output; buffered long-latency results; anti-starvation pipeline stall.
// PARAMETERS
//  XLEN          32  datapath width
//  DEPTH          2  long-latency result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT   4  consecutive pipe grants with FIFO non-empty before a forced FIFO grant
// PORTS
//  clock            in   1     system clock
//  reset            in   1     synchronous, active-high reset
//  io_pipe_valid    in   1     writeback stage has a result this cycle
//  io_pipe_rd       in   5     destination register of pipe result
//  io_pipe_data     in   XLEN  pipe result (writeback mux output)
//  io_pipe_stall    out  1     pipe result NOT accepted this cycle; writeback stage must hold
//  io_lat_valid     in   1     long-latency unit offers a result
//  io_lat_rd        in   5     its destination register
//  io_lat_data      in   XLEN  its result
//  io_lat_ready     out  1     FIFO accepts the offered result (valid&ready = push)
//  io_rf_wen        out  1     regfile write enable (registered)
//  io_rf_waddr      out  5     regfile write address (registered)
//  io_rf_wdata      out  XLEN  regfile write data (registered)
//  io_stall_count   out  32    saturating count of io_pipe_stall cycles (ARB_PERF_EN only)
// BEHAVIOUR
//  - Reset: FIFO empty, starve_cnt=0, state IDLE; io_rf_wen=0, io_rf_waddr=0, io_rf_wdata=0,
//    io_pipe_stall=0, io_lat_ready=1, io_stall_count=0. Reset mid-operation drops buffered results.
//  - FIFO: DEPTH entries of {rd,data}, wrap-around pointers + count. io_lat_ready = !full (no
//    same-cycle pop-through when full). Push and pop in same cycle allowed; count unchanged.
//  - States: IDLE (FIFO empty), DRAIN (FIFO non-empty, pipe priority), FORCE (starved).
//    IDLE: pipe granted if valid; lat push goes to FIFO (never direct) -> DRAIN when push.
//    DRAIN: pipe_valid -> grant pipe, starve_cnt++; !pipe_valid -> pop FIFO, starve_cnt=0.
//      starve_cnt reaching STARVE_LIMIT -> FORCE. Last pop with no push -> IDLE.
//    FORCE: io_pipe_stall = io_pipe_valid; pop FIFO head; starve_cnt=0; next DRAIN or IDLE per count.
//  - io_pipe_stall is combinational from state only (1 only in FORCE while pipe_valid).
//  - Grant winner registered into io_rf_* next cycle: latency 1. No grant -> io_rf_wen=0,
//    waddr/wdata hold previous value.
//  - rd==0: entry is consumed/granted normally but io_rf_wen forced 0.
//  - Ordering/WAW between FIFO entries and younger pipe results is the issue scoreboard's duty;
//    this block applies FIFO order only.
// CONFIGURATION
//  ARB_PERF_EN defined: io_stall_count increments each cycle io_pipe_stall=1, saturates at 32'hFFFFFFFF,
//    cleared only by reset.
//  ARB_PERF_EN undefined: io_stall_count tied to 0, counter logic absent.
// STRUCTURE
//  Shared package: wb_arb_state_e {IDLE,DRAIN,FORCE}, wb_entry_t {rd[4:0], data[XLEN-1:0]},
//    REG_ZERO=5'd0.
//  One sub-module: wb_result_fifo (DEPTH x wb_entry_t, push/pop/full/empty, synchronous reset).
// TESTING
//  1. Reset then pipe_valid rd=5 data=32'h1234 -> next cycle rf_wen=1 waddr=5 wdata=32'h1234, stall=0.
//  2. Idle pipe, lat push rd=7 data=32'hCAFE -> pop next cycle, rf write rd=7 one cycle after pop.
//  3. FIFO full (2 pushes, pipe busy) -> lat_ready=0; third lat_valid held until a pop frees a slot.
//  4. pipe_valid every cycle with 1 FIFO entry -> 4 pipe writes, then 1 stall cycle writing FIFO entry,
//     stall_count=1 (ARB_PERF_EN).
//  5. pipe rd=0 data=32'hFFFF -> rf_wen stays 0; lat rd=0 entry popped with rf_wen=0, FIFO empties.
//  6. Reset asserted with 2 FIFO entries -> next cycle empty, lat_ready=1, rf_wen=0, state IDLE.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: FSM states, buffered result entry, zero register.
package wb_port_arbiter_pkg;

  localparam int unsigned WB_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FORCE = 2'd2
  } wb_arb_state_e;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer for long-latency results; wrap-around pointers plus occupancy count.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = wb_entry_t,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through a non-zero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter between writeback pipe and buffered long-latency results.
// Optional stall-cycle performance counter enabled by defining ARB_PERF_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_pipe_valid,
  input  logic [4:0]      io_pipe_rd,
  input  logic [XLEN-1:0] io_pipe_data,
  output logic            io_pipe_stall,
  input  logic            io_lat_valid,
  input  logic [4:0]      io_lat_rd,
  input  logic [XLEN-1:0] io_lat_data,
  output logic            io_lat_ready,
  output logic            io_rf_wen,
  output logic [4:0]      io_rf_waddr,
  output logic [XLEN-1:0] io_rf_wdata,
  output logic [31:0]     io_stall_count
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  wb_arb_state_e   state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_last;
  logic [CW-1:0]   fifo_count;
  entry_t          fifo_head, lat_entry;
  logic            pipe_grant, grant;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  assign lat_entry     = '{rd: io_lat_rd, data: io_lat_data};
  assign io_lat_ready  = !fifo_full;
  assign fifo_push     = io_lat_valid && !fifo_full;
  assign io_pipe_stall = (state_q == FORCE) && io_pipe_valid;
  // FIFO drains to empty this cycle: the final entry leaves and nothing replaces it.
  assign fifo_last     = (fifo_count == CW'(1)) && !fifo_push;

  wb_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .push      (fifo_push),
    .push_data (lat_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    pipe_grant = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pipe_grant = io_pipe_valid;
        if (fifo_push) state_d = DRAIN;
      end
      DRAIN: begin
        if (io_pipe_valid) begin
          pipe_grant = 1'b1;
          starve_d   = starve_q + SW'(1);
          if (starve_d == SW'(STARVE_LIMIT)) state_d = FORCE;
        end else begin
          fifo_pop = !fifo_empty;
          starve_d = '0;
          state_d  = fifo_last ? IDLE : DRAIN;
        end
      end
      FORCE: begin
        fifo_pop = !fifo_empty;
        starve_d = '0;
        state_d  = fifo_last ? IDLE : DRAIN;
      end
      default: begin
        state_d  = IDLE;
        starve_d = '0;
      end
    endcase
  end

  assign grant    = pipe_grant || fifo_pop;
  assign win_rd   = pipe_grant ? io_pipe_rd   : fifo_head.rd;
  assign win_data = pipe_grant ? io_pipe_data : fifo_head.data;

  always_comb begin
    rf_wen_d   = grant && (win_rd != REG_ZERO);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant) begin
      rf_waddr_d = win_rd;
      rf_wdata_d = win_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign io_rf_wen   = rf_wen_q;
  assign io_rf_waddr = rf_waddr_q;
  assign io_rf_wdata = rf_wdata_q;

`ifdef ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (io_pipe_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign io_stall_count = stall_cnt_q;
`else
  assign io_stall_count = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, corner sequences, random vs. model.
module tb_wb_port_arbiter;

  localparam int XLEN         = 32;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            io_pipe_valid = 1'b0;
  logic [4:0]      io_pipe_rd = '0;
  logic [XLEN-1:0] io_pipe_data = '0;
  logic            io_pipe_stall;
  logic            io_lat_valid = 1'b0;
  logic [4:0]      io_lat_rd = '0;
  logic [XLEN-1:0] io_lat_data = '0;
  logic            io_lat_ready;
  logic            io_rf_wen;
  logic [4:0]      io_rf_waddr;
  logic [XLEN-1:0] io_rf_wdata;
  logic [31:0]     io_stall_count;

  always #5 clock = ~clock;

  wb_port_arbiter #(
    .XLEN         (XLEN),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_pipe_valid  (io_pipe_valid),
    .io_pipe_rd     (io_pipe_rd),
    .io_pipe_data   (io_pipe_data),
    .io_pipe_stall  (io_pipe_stall),
    .io_lat_valid   (io_lat_valid),
    .io_lat_rd      (io_lat_rd),
    .io_lat_data    (io_lat_data),
    .io_lat_ready   (io_lat_ready),
    .io_rf_wen      (io_rf_wen),
    .io_rf_waddr    (io_rf_waddr),
    .io_rf_wdata    (io_rf_wdata),
    .io_stall_count (io_stall_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_stall;
    logic        e_ready;
    logic        e_wen;
    logic        e_chk;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic pv, input logic [4:0] prd,
                              input logic [31:0] pd, input logic lv, input logic [4:0] lrd,
                              input logic [31:0] ld, input logic e_stall, input logic e_ready,
                              input logic e_wen, input logic e_chk, input logic [4:0] e_addr,
                              input logic [31:0] e_data);
    vec_t v;
    v.rst = rst; v.pv = pv; v.prd = prd; v.pd = pd; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_wen = e_wen; v.e_chk = e_chk;
    v.e_addr = e_addr; v.e_data = e_data;
    return v;
  endfunction

  // Called just after an active edge: drive, check handshake outputs, clock, check regfile outputs.
  task automatic run_vec(input vec_t v, input string tag);
    reset         = v.rst;
    io_pipe_valid = v.pv;
    io_pipe_rd    = v.prd;
    io_pipe_data  = v.pd;
    io_lat_valid  = v.lv;
    io_lat_rd     = v.lrd;
    io_lat_data   = v.ld;
    #1;
    chk({tag, "_stall"}, 32'(io_pipe_stall), 32'(v.e_stall));
    chk({tag, "_ready"}, 32'(io_lat_ready), 32'(v.e_ready));
    @(posedge clock); #1;
    chk({tag, "_wen"}, 32'(io_rf_wen), 32'(v.e_wen));
    if (v.e_wen || v.e_chk) begin
      chk({tag, "_waddr"}, 32'(io_rf_waddr), 32'(v.e_addr));
      chk({tag, "_wdata"}, io_rf_wdata, v.e_data);
    end
  endtask

  // Reference model: queue of pending results plus a count of consecutive pipe wins.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve;
  logic [31:0] m_sc;

  task automatic model_step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                            input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                            output logic stall, output logic ready, output logic wr,
                            output logic [4:0] wrd, output logic [31:0] wd);
    logic grant;
    ent_t e;
    grant = 1'b0;
    wrd   = '0;
    wd    = '0;
    stall = (m_starve >= STARVE_LIMIT) && pv;
    ready = (m_q.size() < DEPTH);
    if (m_starve >= STARVE_LIMIT) begin
      e = m_q.pop_front();
      grant = 1'b1; wrd = e.rd; wd = e.data;
      m_starve = 0;
    end else if (m_q.size() != 0) begin
      if (pv) begin
        grant = 1'b1; wrd = prd; wd = pd;
        m_starve++;
      end else begin
        e = m_q.pop_front();
        grant = 1'b1; wrd = e.rd; wd = e.data;
        m_starve = 0;
      end
    end else if (pv) begin
      grant = 1'b1; wrd = prd; wd = pd;
    end
    if (lv && ready) m_q.push_back('{rd: lrd, data: ld});
    if (stall && m_sc != 32'hFFFF_FFFF) m_sc++;
    wr = grant && (wrd != 5'd0);
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = mk(1, 0, 0,  0,       0, 0,  0,       0, 1, 0, 1, 0,  0);
    tbl[1]  = mk(0, 1, 5,  'h1234,  0, 0,  0,       0, 1, 1, 1, 5,  'h1234);
    tbl[2]  = mk(0, 0, 0,  0,       0, 0,  0,       0, 1, 0, 1, 5,  'h1234);
    tbl[3]  = mk(0, 0, 0,  0,       1, 7,  'hCAFE,  0, 1, 0, 1, 5,  'h1234);
    tbl[4]  = mk(0, 0, 0,  0,       0, 0,  0,       0, 1, 1, 1, 7,  'hCAFE);
    tbl[5]  = mk(0, 0, 0,  0,       0, 0,  0,       0, 1, 0, 1, 7,  'hCAFE);
    tbl[6]  = mk(0, 1, 1,  'h11,    1, 8,  'h88,    0, 1, 1, 1, 1,  'h11);
    tbl[7]  = mk(0, 1, 2,  'h22,    1, 9,  'h99,    0, 1, 1, 1, 2,  'h22);
    tbl[8]  = mk(0, 1, 3,  'h33,    1, 10, 'hAA,    0, 0, 1, 1, 3,  'h33);
    tbl[9]  = mk(0, 0, 0,  0,       1, 10, 'hAA,    0, 0, 1, 1, 8,  'h88);
    tbl[10] = mk(0, 0, 0,  0,       1, 10, 'hAA,    0, 1, 1, 1, 9,  'h99);
    tbl[11] = mk(0, 0, 0,  0,       0, 0,  0,       0, 1, 1, 1, 10, 'hAA);
    tbl[12] = mk(0, 1, 0,  'hFFFF,  0, 0,  0,       0, 1, 0, 0, 0,  0);
    tbl[13] = mk(0, 0, 0,  0,       1, 0,  'h5555,  0, 1, 0, 0, 0,  0);
    tbl[14] = mk(0, 0, 0,  0,       0, 0,  0,       0, 1, 0, 0, 0,  0);
    tbl[15] = mk(0, 0, 0,  0,       1, 4,  'h44,    0, 1, 0, 0, 0,  0);
    tbl[16] = mk(0, 0, 0,  0,       0, 0,  0,       0, 1, 1, 1, 4,  'h44);

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wen", 32'(io_rf_wen), 32'd0);
    chk("rst_stall_count", io_stall_count, 32'd0);

    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Starvation: one buffered entry while the pipe writes every cycle.
    run_vec(mk(0, 1, 10, 'h100, 1, 6, 'h66, 0, 1, 1, 1, 10, 'h100), "starve0");
    for (int k = 1; k <= 4; k++)
      run_vec(mk(0, 1, 5'(10 + k), 32'('h100 + k), 0, 0, 0, 0, 1, 1, 1, 5'(10 + k),
                 32'('h100 + k)), $sformatf("starve%0d", k));
    run_vec(mk(0, 1, 15, 'h105, 0, 0, 0, 1, 1, 1, 1, 6, 'h66), "force");
    chk("force_stall_count", io_stall_count, PERF ? 32'd1 : 32'd0);
    run_vec(mk(0, 1, 15, 'h105, 0, 0, 0, 0, 1, 1, 1, 15, 'h105), "after_force");
    chk("after_force_stall_count", io_stall_count, PERF ? 32'd1 : 32'd0);

    // Reset with two buffered entries drops them.
    run_vec(mk(0, 1, 20, 'h200, 1, 21, 'h210, 0, 1, 1, 1, 20, 'h200), "fill0");
    run_vec(mk(0, 1, 22, 'h220, 1, 23, 'h230, 0, 1, 1, 1, 22, 'h220), "fill1");
    run_vec(mk(0, 1, 24, 'h240, 0, 0,  0,     0, 0, 1, 1, 24, 'h240), "fill2");
    run_vec(mk(1, 0, 0,  0,     0, 0,  0,     0, 0, 0, 1, 0,  0),     "midrst");
    chk("midrst_stall_count", io_stall_count, 32'd0);
    run_vec(mk(0, 0, 0,  0,     0, 0,  0,     0, 1, 0, 1, 0,  0),     "postrst");

    // Randomized traffic against the reference model.
    reset = 1'b1;
    io_pipe_valid = 1'b0;
    io_lat_valid  = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_q.delete();
    m_starve = 0;
    m_sc     = '0;
    for (int n = 0; n < 2000; n++) begin
      logic        pv, lv, e_stall, e_ready, e_wen;
      logic [4:0]  prd, lrd, e_rd;
      logic [31:0] pd, ld, e_d;
      pv  = ($urandom_range(0, 3) != 0);
      lv  = ($urandom_range(0, 4) < 2);
      prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pd  = $urandom;
      ld  = $urandom;
      io_pipe_valid = pv; io_pipe_rd = prd; io_pipe_data = pd;
      io_lat_valid  = lv; io_lat_rd  = lrd; io_lat_data  = ld;
      model_step(pv, prd, pd, lv, lrd, ld, e_stall, e_ready, e_wen, e_rd, e_d);
      #1;
      chk("rnd_stall", 32'(io_pipe_stall), 32'(e_stall));
      chk("rnd_ready", 32'(io_lat_ready), 32'(e_ready));
      @(posedge clock); #1;
      chk("rnd_wen", 32'(io_rf_wen), 32'(e_wen));
      if (e_wen) begin
        chk("rnd_waddr", 32'(io_rf_waddr), 32'(e_rd));
        chk("rnd_wdata", io_rf_wdata, e_d);
      end
      chk("rnd_stall_count", io_stall_count, PERF ? m_sc : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
